freq_divider_mc: RTL and testbench
==================================

FREQ_DIVIDER_MC -- requirements
Module: freq_divider_mc

Interface
REQ-001 Parameter NCH, default 4, number of independent output channels (1..16).
REQ-002 Parameter WIDTH, default 32, bit width of the counter and every config field (2..32).
REQ-003 Parameter CHW, derived as max(1, ceil(log2(NCH))), channel-select width.
REQ-004 Clk  input  1  clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Din  input  WIDTH  config write data.
REQ-007 CfgWr  input  1  single-cycle config write strobe.
REQ-008 CfgCh  input  CHW  target channel of the write.
REQ-009 CfgField  input  2  field select: 0 = PERIOD, 1 = HIGH, 2 = PHASE, 3 = reserved.
REQ-010 Enable  input  NCH  per-channel run enable, level-sensitive.
REQ-011 ClkOut  output  NCH  per-channel divided clock, registered and glitch-free.
REQ-012 Tick  output  NCH  per-channel one-cycle pulse at each period start.
REQ-013 CfgErr  output  1  one-cycle pulse flagging a rejected write.

Function
REQ-014 Each channel SHALL hold registers PERIOD, HIGH and PHASE (WIDTH bits each), a counter CNT, and a RUN flag; RUN is the registered copy of Enable[i].
REQ-015 A write SHALL be accepted only if CfgCh < NCH, CfgField != 3, Enable[CfgCh] = 0 and RUN[CfgCh] = 0; otherwise the write is dropped and CfgErr = 1 on the following cycle.
REQ-016 An accepted PERIOD write SHALL store max(Din, 2); HIGH and PHASE SHALL store Din unmodified.
REQ-017 Start value START = PHASE if PHASE < PERIOD, else 0.
REQ-018 At the edge where Enable[i] = 1 and RUN[i] = 0 (start edge), the channel SHALL set CNT <= START, ClkOut[i] <= (START < HIGH), and Tick[i] <= (START == 0).
REQ-019 At each edge where Enable[i] = 1 and RUN[i] = 1, the channel SHALL set N = (CNT == PERIOD-1) ? 0 : CNT+1, CNT <= N, ClkOut[i] <= (N < HIGH), and Tick[i] <= (N == 0).
REQ-020 Output period SHALL be exactly PERIOD Clk cycles; high time SHALL be min(HIGH, PERIOD) cycles per period.
REQ-021 HIGH = 0 SHALL hold ClkOut[i] constantly low while running; HIGH >= PERIOD SHALL hold it constantly high; Tick[i] still pulses every PERIOD cycles in both cases.
REQ-022 At any edge with Enable[i] = 0, the channel SHALL set CNT <= 0, ClkOut[i] <= 0, and Tick[i] <= 0; deassertion is honoured immediately, mid-period.
REQ-023 Re-asserting Enable[i] after any gap SHALL restart from START, with no memory of the previous phase.
REQ-024 Channels SHALL be fully independent; a write or enable on one channel SHALL not disturb any other channel's counter or outputs.
REQ-025 All compares SHALL be unsigned WIDTH-bit; CNT SHALL never exceed PERIOD-1 and SHALL not overflow.
REQ-026 ClkOut and Tick SHALL be driven only from flops; no combinational path from Clk or Enable reaches any output.

Reset
REQ-027 Reset SHALL asynchronously force PERIOD = 2, HIGH = 1, PHASE = 0, CNT = 0, RUN = 0, ClkOut = 0, Tick = 0 and CfgErr = 0 on all channels.
REQ-028 Reset asserted mid-operation SHALL stop every channel immediately; after release, each channel restarts per REQ-018 only while its Enable is high.

Verification
REQ-029 Reset, then hold Enable[0] = 1 -> ClkOut[0] toggles every cycle (divide-by-2) and Tick[0] pulses every 2 cycles, the first at the start edge.
REQ-030 Ch1: PERIOD = 5, HIGH = 2, PHASE = 0, then enable -> pattern 1,1,0,0,0 repeats; Tick[1] asserts in the cycles where ClkOut[1] rises.
REQ-031 Ch2: PERIOD = 4, HIGH = 2, PHASE = 3, then enable -> first values 0,1,1,0,0,1,1; Tick[2] on the second cycle and every 4 thereafter.
REQ-032 Write PERIOD = 7 to ch0 while Enable[0] = 1; also write with CfgField = 3, and with CfgCh = NCH (NCH < 2^CHW) -> three CfgErr pulses, registers unchanged, ch0 waveform undisturbed.
REQ-033 Write PERIOD = 0, HIGH = 9 and enable ch3 -> PERIOD reads back as 2 and ClkOut[3] stays high with Tick[3] every 2 cycles; then HIGH = 0 -> ClkOut[3] stays low.
REQ-034 Drop Enable[1] mid-period, and separately pulse Reset while all channels run -> ClkOut and Tick go low within one edge (Reset immediately); re-enable restarts from START.

Source files
------------

// File: rtl/freq_divider_mc.sv
// rtl/freq_divider_mc.sv - multi-channel programmable clock divider with per-channel period, high time and phase
module freq_divider_mc #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             CfgWr,
  input  logic [CHW-1:0]   CfgCh,
  input  logic [1:0]       CfgField,
  input  logic [NCH-1:0]   Enable,
  output logic [NCH-1:0]   ClkOut,
  output logic [NCH-1:0]   Tick,
  output logic             CfgErr
);

  localparam logic [1:0]       FIELD_PERIOD = 2'd0;
  localparam logic [1:0]       FIELD_HIGH   = 2'd1;
  localparam logic [1:0]       FIELD_PHASE  = 2'd2;
  localparam logic [WIDTH-1:0] MIN_PERIOD   = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);
  localparam logic [CHW:0]     NCH_W        = (CHW+1)'(NCH);

  logic [WIDTH-1:0] period_q [NCH];
  logic [WIDTH-1:0] high_q   [NCH];
  logic [WIDTH-1:0] phase_q  [NCH];
  logic [WIDTH-1:0] cnt_q    [NCH];
  logic [NCH-1:0]   run_q;

  logic [WIDTH-1:0] start_v  [NCH];
  logic [WIDTH-1:0] next_v   [NCH];
  logic [WIDTH-1:0] cnt_d    [NCH];
  logic [NCH-1:0]   clk_d;
  logic [NCH-1:0]   tick_d;
  logic [NCH-1:0]   sel;
  logic             ch_busy;
  logic             ch_valid;
  logic             wr_ok;

  // Decode by loop so an out-of-range CfgCh never indexes past Enable.
  always_comb begin
    sel     = '0;
    ch_busy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (CfgCh == CHW'(i)) begin
        sel[i]  = 1'b1;
        ch_busy = Enable[i] | run_q[i];
      end
    end
    ch_valid = {1'b0, CfgCh} < NCH_W;
    wr_ok    = CfgWr && ch_valid && (CfgField != 2'd3) && !ch_busy;
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      start_v[i] = (phase_q[i] < period_q[i]) ? phase_q[i] : '0;
      next_v[i]  = (cnt_q[i] == period_q[i] - ONE) ? '0 : cnt_q[i] + ONE;
      if (!Enable[i])
        cnt_d[i] = '0;
      else if (!run_q[i])
        cnt_d[i] = start_v[i];
      else
        cnt_d[i] = next_v[i];
      clk_d[i]  = Enable[i] && (cnt_d[i] < high_q[i]);
      tick_d[i] = Enable[i] && (cnt_d[i] == '0);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= MIN_PERIOD;
        high_q[i]   <= ONE;
        phase_q[i]  <= '0;
        cnt_q[i]    <= '0;
      end
      run_q  <= '0;
      ClkOut <= '0;
      Tick   <= '0;
      CfgErr <= 1'b0;
    end else begin
      run_q  <= Enable;
      ClkOut <= clk_d;
      Tick   <= tick_d;
      CfgErr <= CfgWr && !wr_ok;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        // Writes only land on idle channels, so a running counter never sees its config move.
        if (wr_ok && sel[i]) begin
          case (CfgField)
            FIELD_PERIOD: period_q[i] <= (Din < MIN_PERIOD) ? MIN_PERIOD : Din;
            FIELD_HIGH:   high_q[i]   <= Din;
            FIELD_PHASE:  phase_q[i]  <= Din;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_divider_mc.sv
// tb/tb_freq_divider_mc.sv - directed bench for freq_divider_mc
module tb_freq_divider_mc;

  localparam int NCH   = 5;
  localparam int WIDTH = 16;
  localparam int CHW   = 3;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [WIDTH-1:0] Din;
  logic             CfgWr;
  logic [CHW-1:0]   CfgCh;
  logic [1:0]       CfgField;
  logic [NCH-1:0]   Enable;
  logic [NCH-1:0]   ClkOut;
  logic [NCH-1:0]   Tick;
  logic             CfgErr;

  int n_chk  = 0;
  int n_pass = 0;

  freq_divider_mc #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Din(Din), .CfgWr(CfgWr), .CfgCh(CfgCh),
    .CfgField(CfgField), .Enable(Enable), .ClkOut(ClkOut), .Tick(Tick), .CfgErr(CfgErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic cfg_write(input logic [CHW-1:0] ch, input logic [1:0] fld,
                           input logic [WIDTH-1:0] d, input logic err_exp, input string tag);
    CfgWr = 1'b1; CfgCh = ch; CfgField = fld; Din = d;
    step();
    CfgWr = 1'b0;
    check(tag, CfgErr, err_exp);
  endtask

  logic [0:6] p1c = 7'b1100011;
  logic [0:6] p1t = 7'b1000010;
  logic [0:6] p2c = 7'b0110011;
  logic [0:6] p2t = 7'b0100010;

  initial begin
    Reset = 1'b1; CfgWr = 1'b0; Din = '0; CfgCh = '0; CfgField = '0; Enable = '0;
    step(); step();
    check("rst_clkout", ClkOut, 0);
    check("rst_tick", Tick, 0);
    check("rst_cfgerr", CfgErr, 0);
    Reset = 1'b0;
    step();

    cfg_write(3'd1, 2'd0, 16'd5, 1'b0, "wr_ch1_period");
    cfg_write(3'd1, 2'd1, 16'd2, 1'b0, "wr_ch1_high");
    cfg_write(3'd1, 2'd2, 16'd0, 1'b0, "wr_ch1_phase");
    cfg_write(3'd2, 2'd0, 16'd4, 1'b0, "wr_ch2_period");
    cfg_write(3'd2, 2'd1, 16'd2, 1'b0, "wr_ch2_high");
    cfg_write(3'd2, 2'd2, 16'd3, 1'b0, "wr_ch2_phase");
    cfg_write(3'd3, 2'd0, 16'd0, 1'b0, "wr_ch3_period0");
    cfg_write(3'd3, 2'd1, 16'd9, 1'b0, "wr_ch3_high9");

    // ch0 default divide-by-2, 6 edges (ch0 edges 0..5)
    Enable = 5'b00001;
    for (int k = 0; k < 6; k++) begin
      step();
      check("div2_clk", ClkOut[0], (k % 2) == 0);
      check("div2_tick", Tick[0], (k % 2) == 0);
    end

    // ch1 period 5 high 2 phase 0 (ch0 edges 6..12)
    Enable = 5'b00011;
    for (int k = 0; k < 7; k++) begin
      step();
      check("ch1_clk", ClkOut[1], p1c[k]);
      check("ch1_tick", Tick[1], p1t[k]);
    end

    // ch2 period 4 high 2 phase 3 (ch0 edges 13..19)
    Enable = 5'b00111;
    for (int k = 0; k < 7; k++) begin
      step();
      check("ch2_clk", ClkOut[2], p2c[k]);
      check("ch2_tick", Tick[2], p2t[k]);
    end

    // rejected writes; ch0 continues at edge 20 onward
    cfg_write(3'd0, 2'd0, 16'd7, 1'b1, "err_busy");
    check("err_busy_ch0", ClkOut[0], 1);
    cfg_write(3'd3, 2'd3, 16'd1, 1'b1, "err_field3");
    check("err_field3_ch0", ClkOut[0], 0);
    cfg_write(3'd5, 2'd0, 16'd3, 1'b1, "err_badch");
    check("err_badch_ch0", ClkOut[0], 1);
    step();
    check("err_one_cycle", CfgErr, 0);
    check("err_after_ch0", ClkOut[0], 0);
    step();
    check("ch0_period_kept_clk", ClkOut[0], 1);
    check("ch0_period_kept_tick", Tick[0], 1);

    // ch3 period clamped to 2, high 9 -> constantly high
    Enable = 5'b01111;
    for (int k = 0; k < 4; k++) begin
      step();
      check("ch3_hi_clk", ClkOut[3], 1);
      check("ch3_hi_tick", Tick[3], (k % 2) == 0);
    end
    Enable = 5'b00111;
    step();
    check("ch3_off_clk", ClkOut[3], 0);
    check("ch3_off_tick", Tick[3], 0);
    cfg_write(3'd3, 2'd1, 16'd0, 1'b0, "wr_ch3_high0");
    Enable = 5'b01111;
    for (int k = 0; k < 4; k++) begin
      step();
      check("ch3_lo_clk", ClkOut[3], 0);
      check("ch3_lo_tick", Tick[3], (k % 2) == 0);
    end

    // drop ch1 mid-period and re-enable from START
    Enable = 5'b01101;
    step();
    check("ch1_drop_clk", ClkOut[1], 0);
    check("ch1_drop_tick", Tick[1], 0);
    step();
    Enable = 5'b01111;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ch1_restart_clk", ClkOut[1], p1c[k]);
      check("ch1_restart_tick", Tick[1], p1t[k]);
    end

    // asynchronous reset while running restores defaults
    Reset = 1'b1;
    #1;
    check("async_rst_clkout", ClkOut, 0);
    check("async_rst_tick", Tick, 0);
    step();
    check("rst_hold_clkout", ClkOut, 0);
    check("rst_hold_cfgerr", CfgErr, 0);
    Reset = 1'b0;
    step();
    check("post_rst_clkout0", ClkOut, 5'b01111);
    check("post_rst_tick0", Tick, 5'b01111);
    step();
    check("post_rst_clkout1", ClkOut, 5'b00000);
    check("post_rst_tick1", Tick, 5'b00000);
    step();
    check("post_rst_clkout2", ClkOut, 5'b01111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
